// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch block: memory map constants,
// fetch FSM state encoding, the fetch FIFO entry layout and the PC legality
// check used when deciding whether a fetch may go to instruction memory.
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    // First fetch address after reset and instruction memory depth in words.
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int unsigned IM_WORDS  = 4096;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // End of the legal PC window, kept in 33 bits so that a window ending at
    // the top of the address space does not wrap to zero.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_FULL
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    // A PC may be fetched only if it is word aligned and inside
    // [RESET_PC, RESET_PC + 4*IM_WORDS).
    function automatic logic pc_legal(input logic [31:0] pc_v);
        return (pc_v[1:0] == 2'b00) &&
               (pc_v >= RESET_PC) &&
               ({1'b0, pc_v} < PC_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry FIFO between instruction fetch and decode. The head entry drives
// the decode-facing outputs directly from registers.
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-low reset
//   push, push_data  write an entry at the tail (ignored during a flush)
//   pop              remove the head entry (caller guarantees count != 0)
//   flush_keep_head  drop every entry behind the head; combined with pop the
//                    FIFO ends up empty
//   head             current head entry
//   count            number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush_keep_head,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: RESET_PC, err: 1'b0};

    fetch_entry_t slot0_q;
    fetch_entry_t slot1_q;
    logic [1:0]   count_q;

    // NOTE: the two slots are only flops, so they are reset along with the
    // count; this is what makes the idle head read as NOP at RESET_PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0_q <= EMPTY_ENTRY;
            slot1_q <= EMPTY_ENTRY;
            count_q <= 2'd0;
        end else if (flush_keep_head) begin
            count_q <= (pop || count_q == 2'd0) ? 2'd0 : 2'd1;
        end else begin
            // NOTE: non-blocking assignments let slot0 take the old slot1
            // while slot1 takes the new entry on the same edge.
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= push_data;
                    else                 slot1_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data;
                    end else begin
                        slot0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer for the pipelined MIPS core. Owns the fetch PC,
// talks to a variable-latency instruction memory over req/ack, buffers up to
// two instructions for decode and applies taken branches/jumps with delay-slot
// semantics. Illegal PCs never reach memory; they produce a NOP entry with
// addr_err set.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   stall               decode cannot accept the head this cycle
//   redirect_valid/pc   taken branch/jump in decode and its target
//   im_req/im_addr      memory request and word index (pc_q-RESET_PC)>>2
//   im_ack/im_rdata     memory response for the current im_addr
//   instr_valid, instr, pc, pc_plus4, addr_err   FIFO head towards decode
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [11:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;           // pending redirect target
    logic         tgt_valid_q, tgt_valid_d;
    logic         drop_q, drop_d;         // outstanding response must be discarded

    fetch_entry_t head;
    fetch_entry_t push_data;
    logic [1:0]   count;
    logic [1:0]   count_nx;
    logic         push, pop, flush;
    logic         pc_ok, step, redir;

    assign pc_ok  = pc_legal(pc_q);
    assign im_req = (state_q == S_REQ) && pc_ok;
    assign im_addr = 12'((pc_q - RESET_PC) >> 2);

    // The current fetch slot resolves this cycle: either memory answered, or
    // the PC is illegal and the error entry is produced without a request.
    assign step  = (state_q == S_REQ) && (pc_ok ? im_ack : 1'b1);
    assign pop   = instr_valid && !stall;
    assign redir = redirect_valid && !stall;

    assign push_data = '{instr: pc_ok ? im_rdata : NOP_INSTR, pc: pc_q, err: !pc_ok};

    // NOTE: every signal driven here gets a default first, so no path through
    // the ifs can leave one unassigned and infer a latch.
    always_comb begin
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        tgt_valid_d = tgt_valid_q;
        drop_d      = drop_q;
        push        = 1'b0;
        flush       = 1'b0;

        if (step) begin
            push        = !drop_q;
            pc_d        = tgt_valid_q ? tgt_q : pc_q + 32'd4;
            tgt_valid_d = 1'b0;
            drop_d      = 1'b0;
        end

        if (redir) begin
            if (count != 2'd0) begin
                // Head leaves as the delay slot; anything fetched after it is
                // on the wrong path.
                flush = 1'b1;
                push  = 1'b0;
                if (im_req && !im_ack) begin
                    // Keep im_addr stable until the stray response arrives.
                    pc_d        = pc_q;
                    drop_d      = 1'b1;
                    tgt_valid_d = 1'b1;
                    tgt_d       = redirect_pc;
                end else begin
                    pc_d        = redirect_pc;
                    drop_d      = 1'b0;
                    tgt_valid_d = 1'b0;
                end
            end else if (step) begin
                // The slot resolving right now is the delay slot.
                pc_d = redirect_pc;
            end else begin
                // Delay slot still in flight: jump once it lands.
                tgt_valid_d = 1'b1;
                tgt_d       = redirect_pc;
            end
        end
    end

    always_comb begin
        if (flush) count_nx = 2'd0;
        else       count_nx = count + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_REQ;
            S_REQ:   if (count_nx == 2'd2) state_d = S_FULL;
            S_FULL:  if (count_nx != 2'd2) state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            tgt_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            tgt_valid_q <= tgt_valid_d;
            drop_q      <= drop_d;
        end
    end

    fetch_fifo u_fifo (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .push_data       (push_data),
        .pop             (pop),
        .flush_keep_head (flush),
        .head            (head),
        .count           (count)
    );

    assign instr_valid = (count != 2'd0);
    assign instr       = head.instr;
    assign pc          = head.pc;
    assign pc_plus4    = head.pc + 32'd4;
    assign addr_err    = head.err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. A behavioural instruction memory answers with
// a programmable wait; every instruction decode consumes is checked against a
// queue of hand-listed expected entries, alongside direct checks of handshake
// and head state at the interesting cycles.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [11:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    int   ack_delay = 0;
    int   wait_cnt;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_ack         (im_ack),
        .im_rdata       (im_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .addr_err       (addr_err)
    );

    // Memory: word at index a is C0DE_0000 | a, answered after ack_delay
    // cycles of continuous request.
    assign im_ack   = im_req && (wait_cnt >= ack_delay);
    assign im_rdata = 32'hC0DE_0000 | {20'h0, im_addr};

    always @(posedge clk or negedge reset) begin
        if (!reset)                 wait_cnt <= 0;
        else if (!im_req || im_ack) wait_cnt <= 0;
        else                        wait_cnt <= wait_cnt + 1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] p);
        logic [31:0] off;
        off = p - 32'h0000_3000;
        return 32'hC0DE_0000 | {20'h0, off[13:2]};
    endfunction

    task automatic expect_entry(input logic [31:0] p, input logic err);
        exp_t e;
        e.pc    = p;
        e.err   = err;
        e.instr = err ? 32'h0 : mem_word(p);
        exp_q.push_back(e);
    endtask

    // Monitor: decode consumes the head on the coming edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && instr_valid && !stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h err=%b, required no delivery",
                         pc, instr, addr_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc !== e.pc || instr !== e.instr || addr_err !== e.err) begin
                    n_fail++;
                    $display("FAIL pop_entry: got pc=%h instr=%h err=%b, required pc=%h instr=%h err=%b",
                             pc, instr, addr_err, e.pc, e.instr, e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_head(input logic [31:0] want, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (instr_valid && pc == want) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_head: head pc %h not seen within %0d cycles, head is %h", want, budget, pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // ---------------- reset state
        repeat (3) tick();
        check("rst_im_req",      {31'h0, im_req},      32'h0);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr",       instr,                32'h0);
        check("rst_pc",          pc,                   32'h3000);
        check("rst_pc_plus4",    pc_plus4,             32'h3004);
        check("rst_addr_err",    {31'h0, addr_err},    32'h0);

        // ---------------- boot, zero-wait memory
        expect_entry(32'h3000, 1'b0);
        expect_entry(32'h3004, 1'b0);
        expect_entry(32'h3008, 1'b0);
        expect_entry(32'h300c, 1'b0);
        expect_entry(32'h3010, 1'b0);
        expect_entry(32'h3100, 1'b0);
        expect_entry(32'h3102, 1'b1);
        reset = 1'b1;
        tick();
        check("boot_im_req",  {31'h0, im_req},      32'h1);
        check("boot_im_addr", {20'h0, im_addr},     32'h0);
        check("boot_empty",   {31'h0, instr_valid}, 32'h0);
        tick();
        check("boot_pc0", pc, 32'h3000);
        tick();
        check("boot_pc1", pc, 32'h3004);
        tick();
        check("boot_pc2", pc, 32'h3008);

        // ---------------- stall fills the FIFO and freezes the head
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_im_req",  {31'h0, im_req}, 32'h0);
            check("stall_head_pc", pc,              32'h3008);
        end
        stall = 1'b0;

        // ---------------- redirect with two entries buffered
        wait_head(32'h3010, 10);
        stall = 1'b1;
        tick();
        check("full2_im_req", {31'h0, im_req}, 32'h0);
        check("full2_head",   pc,              32'h3010);
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        tick();
        redirect_valid = 1'b0;
        check("redir2_flushed", {31'h0, instr_valid}, 32'h0);
        check("redir2_im_addr", {20'h0, im_addr},     32'h40);
        wait_head(32'h3100, 10);

        // ---------------- misaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3102;
        tick();
        redirect_valid = 1'b0;
        check("misal_no_req", {31'h0, im_req}, 32'h0);
        tick();
        check("misal_valid",    {31'h0, instr_valid}, 32'h1);
        check("misal_pc",       pc,                   32'h3102);
        check("misal_instr",    instr,                32'h0);
        check("misal_err",      {31'h0, addr_err},    32'h1);
        check("misal_pc_plus4", pc_plus4,             32'h3106);
        check("misal_still_no_req", {31'h0, im_req},  32'h0);
        tick();
        stall = 1'b1;
        repeat (2) tick();
        check("phase_a_drained", exp_q.size(), 32'h0);

        // ---------------- delayed memory, redirect with empty FIFO
        reset = 1'b0;
        stall = 1'b0;
        ack_delay = 3;
        repeat (2) tick();
        expect_entry(32'h3000, 1'b0);
        expect_entry(32'h3004, 1'b0);
        expect_entry(32'h3200, 1'b0);
        expect_entry(32'h3300, 1'b0);
        reset = 1'b1;
        wait_head(32'h3000, 20);
        tick();
        check("empty_before_redir", {31'h0, instr_valid}, 32'h0);
        check("inflight_req",       {31'h0, im_req},      32'h1);
        check("inflight_no_ack",    {31'h0, im_ack},      32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3200;
        tick();
        redirect_valid = 1'b0;
        check("pend_addr_stable", {20'h0, im_addr}, 32'h1);
        wait_head(32'h3200, 30);

        // ---------------- redirect with one entry and a response outstanding
        check("drop_pre_req", {31'h0, im_req}, 32'h1);
        check("drop_pre_ack", {31'h0, im_ack}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3300;
        tick();
        redirect_valid = 1'b0;
        check("drop_empty",       {31'h0, instr_valid}, 32'h0);
        check("drop_addr_stable", {20'h0, im_addr},     32'h81);
        wait_head(32'h3300, 30);
        tick();

        // ---------------- reset while awaiting an ack
        check("mid_req",    {31'h0, im_req}, 32'h1);
        check("mid_no_ack", {31'h0, im_ack}, 32'h0);
        reset = 1'b0;
        #1;
        check("mid_rst_im_req", {31'h0, im_req},      32'h0);
        check("mid_rst_valid",  {31'h0, instr_valid}, 32'h0);
        check("phase_b_drained", exp_q.size(), 32'h0);
        ack_delay = 0;
        repeat (2) tick();
        expect_entry(32'h3000, 1'b0);
        expect_entry(32'h3004, 1'b0);
        reset = 1'b1;
        tick();
        check("refetch_req",  {31'h0, im_req},  32'h1);
        check("refetch_addr", {20'h0, im_addr}, 32'h0);
        repeat (3) tick();
        stall = 1'b1;
        repeat (2) tick();
        check("phase_c_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch datapath of the pipelined MIPS core.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory through a req/ack handshake.
- Buffers up to two fetched instructions for the decode stage and absorbs decode stalls.
- Applies branch/jump redirects with MIPS delay-slot semantics, and flags misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_3000: first fetch address after reset.
- IM_WORDS, 4096: instruction memory depth in words. Legal PC range is [RESET_PC, RESET_PC+4*IM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept this cycle (from the hazard unit).
- redirect_valid  in  1  branch/jump taken in D this cycle.
- redirect_pc  in  32  target of the taken branch/jump.
- im_req  out  1  instruction memory request.
- im_addr  out  12  word index, equal to (pc_q-RESET_PC)>>2.
- im_ack  in  1  response valid for the current im_addr.
- im_rdata  in  32  instruction word returned by memory.
- instr_valid  out  1  FIFO head is valid.
- instr  out  32  FIFO head instruction.
- pc  out  32  FIFO head PC.
- pc_plus4  out  32  pc+4.
- addr_err  out  1  FIFO head was produced from an illegal PC.

Behaviour:
- Reset (reset=0, takes effect immediately):
  - State goes to S_BOOT; pc_q=RESET_PC; FIFO is empty.
  - Outputs: im_req=0, instr_valid=0, instr=0, pc=RESET_PC, pc_plus4=RESET_PC+4, addr_err=0.
  - Reset asserted mid-transaction abandons any outstanding request. The memory must tolerate a dropped req.
- States:
  - S_BOOT: go to S_REQ on the first edge after reset release.
  - S_REQ: im_req=1. im_addr is stable while im_req=1 and no ack has been seen.
  - S_FULL: im_req=0. Entered when the FIFO will hold 2 entries after this edge; leave to S_REQ once count<2 after the edge.
- Handshake:
  - im_ack may arrive in the same cycle as im_req (zero wait) or any later cycle.
  - On ack: push {im_rdata, pc_q, err=0}, then pc_q+=4.
  - In S_REQ, im_req stays high back-to-back, giving 1 instr/cycle with a zero-wait memory.
- Consumption:
  - The head is popped on any edge where instr_valid=1 and stall=0.
  - Pop and push may occur on the same edge; count is unchanged.
- Illegal PC (pc_q[1:0]!=0 or pc_q out of range), checked in S_REQ:
  - No memory request is issued (im_req=0).
  - Push {32'h0000_0000, pc_q, err=1} in one cycle, then pc_q+=4.
- Redirect is accepted only when redirect_valid=1 and stall=0. If redirect_valid=1 while stall=1, it is ignored; D re-presents it.
- Accepted redirect with count>=1:
  - The head pops as the delay slot.
  - All other entries are flushed.
  - Any in-flight response is discarded (drop flag; its ack is consumed without a push).
  - pc_q is set to redirect_pc.
- Accepted redirect with count==0:
  - The in-flight fetch is the delay slot.
  - Keep it: set pend_target=redirect_pc.
  - On its ack, push it and load pc_q=pend_target instead of pc_q+4.
- A second redirect before pend_target resolves overwrites pend_target.
- Arithmetic: 32-bit wraparound on pc_q+4. The upper range check is done on the full 33-bit sum.
- Outputs are driven directly from FIFO head registers; there is no combinational path from im_rdata to instr.

Decomposition:
- Shared package holds:
  - constants RESET_PC, IM_WORDS, NOP_INSTR=32'h0;
  - fetch state encoding {S_BOOT, S_REQ, S_FULL};
  - the FIFO entry struct {instr[31:0], pc[31:0], err}.
- One sub-module, fetch_fifo: 2-entry FIFO with push/pop/flush_keep_head.
- fetch_ctrl contains the FSM, pc_q, the drop/pend_target logic and the range check.

Test Plan:
- Boot, zero-wait memory, stall=0: reset released at t0 -> im_addr=0 at t1; instr_valid from t2 with pc 0x3000, 0x3004, 0x3008 on consecutive cycles.
- stall held high for 5 cycles with zero-wait memory -> FIFO fills to 2, im_req=0 (S_FULL), head pc is frozen. On release: pops resume with no PC skipped or duplicated.
- Redirect with count=2 (heads 0x3010, 0x3014), redirect_pc=0x3100 -> 0x3010 delivered as the delay slot; 0x3014 is flushed; next delivered pc=0x3100.
- Redirect with count=0 and im_ack delayed 3 cycles -> the delayed word (pc 0x3004) is delivered, then fetch continues at redirect_pc.
- redirect_pc=0x3102 (misaligned) -> no im_req; entry delivered with instr=0, addr_err=1, pc=0x3102.
- reset pulled low while im_req=1 and awaiting ack -> im_req=0 and instr_valid=0 immediately; on release, refetch starts at 0x3000.
